rf_writeback: RTL and testbench
===============================

// Module: rf_writeback
// PURPOSE
//  Write-side master for the register file: accepts results from the ALU and load/store
//  unit (LSU), arbitrates them and drives the rfile write port (rd, rd_data, rd_write).
//  ALU results queue in a small in-order FIFO; LSU results have fixed priority and are never
//  stalled. Exposes a pending-write lookup so decode can stall on RAW hazards.
// PARAMETERS
//  FIFO_DEPTH  4   ALU result queue entries; power of 2, >= 2
//  CNT_W       32  width of retired-write counter
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  alu_valid  in   1      ALU result present this cycle
//  alu_ready  out  1      FIFO can accept ALU result (comb: count < FIFO_DEPTH)
//  alu_rd     in   5      ALU destination register index
//  alu_data   in   32     ALU result value
//  lsu_valid  in   1      LSU load result present; always accepted
//  lsu_rd     in   5      LSU destination register index
//  lsu_data   in   32     LSU load value
//  chk_addr   in   5      register index queried by decode
//  chk_hit    out  1      comb: chk_addr!=0 and matches rd of any valid FIFO entry
//  rd         out  32     rfile write address, zero-extended from 5 bits, registered
//  rd_data    out  32     rfile write data, registered
//  rd_write   out  1      rfile write enable, registered, 1-cycle pulse per write
//  wb_count   out  CNT_W  count of writes issued with rd_write=1
//  fifo_cnt   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - Reset: FIFO empty (rd/wr ptr=0, fifo_cnt=0), rd=0, rd_data=0, rd_write=0, wb_count=0.
//    Reset mid-operation discards all queued entries; no write issued in the reset cycle.
//  - Push: alu_valid && alu_ready -> entry {alu_rd, alu_data} written at wr_ptr, wr_ptr++.
//    ALU entries with alu_rd==0 ARE pushed (preserve accept semantics) but dropped at issue.
//  - Select each cycle (priority): lsu_valid -> LSU source; else fifo_cnt!=0 -> pop head;
//    else idle. An entry pushed in cycle N is poppable no earlier than N+1 (no bypass).
//  - Issue (registered, next edge): selected source with index!=0 -> rd={27'b0,idx},
//    rd_data=data, rd_write=1, wb_count++. Index==0 or idle -> rd_write=0; rd/rd_data hold.
//  - Latency: LSU in cycle N -> rd_write in N+1. ALU accepted in N, no LSU in N+1 ->
//    rd_write in N+2. LSU continuously valid starves the FIFO; ALU back-pressures via alu_ready.
//  - Simultaneous push and pop: fifo_cnt unchanged. Full: alu_ready=0 even if a pop occurs
//    the same cycle (no pass-through). Pointers wrap modulo FIFO_DEPTH.
//  - Order: ALU results issue in acceptance order; LSU and ALU writes to the same index
//    issue in arbitration order (decode must use chk_hit to avoid WAW reorder).
//  - wb_count wraps at 2^CNT_W without flag.
//  - chk_hit considers only FIFO entries, not the registered output stage.
// TESTING
//  1 ALU x5=0xDEADBEEF at cyc 1, lsu idle -> cyc 3: rd=5, rd_data=0xDEADBEEF, rd_write=1,
//    wb_count=1; cyc 4 rd_write=0.
//  2 Cyc 1: lsu x3=0x11, alu x7=0x22 -> cyc 2 write x3=0x11; cyc 3 write x7=0x22.
//  3 lsu_valid held 8 cyc, alu_valid held -> 4 accepted, alu_ready=0 from cyc 5, fifo_cnt=4;
//    after LSU drops, 4 ALU writes issue in push order, alu_ready reasserts on first pop.
//  4 alu rd=0 data=0xFFFF -> accepted, no rd_write pulse, wb_count unchanged, fifo drains.
//  5 Queue x9 behind LSU stream; chk_addr=9 -> chk_hit=1 until pop; chk_addr=0 -> chk_hit=0.
//  6 Reset asserted with fifo_cnt=3 -> next cyc fifo_cnt=0, rd_write=0, wb_count=0,
//    alu_ready=1, queued entries never written.

Source files
------------

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - register-file write-side master with ALU result queue and LSU priority
module rf_writeback #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          alu_valid,
   output logic                          alu_ready,
   input  logic [4:0]                    alu_rd,
   input  logic [31:0]                   alu_data,
   input  logic                          lsu_valid,
   input  logic [4:0]                    lsu_rd,
   input  logic [31:0]                   lsu_data,
   input  logic [4:0]                    chk_addr,
   output logic                          chk_hit,
   output logic [31:0]                   rd,
   output logic [31:0]                   rd_data,
   output logic                          rd_write,
   output logic [CNT_W-1:0]              wb_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CW    = PTR_W + 1;

   logic [4:0]       q_rd   [FIFO_DEPTH];
   logic [31:0]      q_data [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   logic             push;
   logic             pop;
   logic             sel_valid;
   logic [4:0]       sel_rd;
   logic [31:0]      sel_data;

   // Full blocks acceptance even when a pop happens in the same cycle.
   assign alu_ready = (fifo_cnt < CW'(FIFO_DEPTH));
   assign push      = alu_valid && alu_ready;
   // LSU always wins; the queue head only drains on cycles with no LSU result.
   assign pop       = !lsu_valid && (fifo_cnt != '0);

   // Pick the write source for this cycle: LSU first, else FIFO head.
   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      if (lsu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = lsu_rd;
         sel_data  = lsu_data;
      end else if (fifo_cnt != '0) begin
         sel_valid = 1'b1;
         sel_rd    = q_rd[rd_ptr];
         sel_data  = q_data[rd_ptr];
      end
   end

   // RAW lookup over occupied queue slots only; x0 never hazards.
   always_comb begin
      chk_hit = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if ((CW'(i) < fifo_cnt) && (chk_addr != 5'd0) &&
             (q_rd[rd_ptr + PTR_W'(i)] == chk_addr)) begin
            chk_hit = 1'b1;
         end
      end
   end

   // Queue storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wr_ptr]   <= alu_rd;
         q_data[wr_ptr] <= alu_data;
      end
   end

   // Queue pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Registered write port; x0 targets and idle cycles leave address/data held.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd       <= '0;
         rd_data  <= '0;
         rd_write <= 1'b0;
         wb_count <= '0;
      end else if (sel_valid && (sel_rd != 5'd0)) begin
         rd       <= {27'b0, sel_rd};
         rd_data  <= sel_data;
         rd_write <= 1'b1;
         wb_count <= wb_count + 1'b1;
      end else begin
         rd_write <= 1'b0;
      end
   end
endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - directed self-checking bench for rf_writeback
module tb_rf_writeback;
   logic        clk;
   logic        reset;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic [4:0]  chk_addr;
   logic        chk_hit;
   logic [31:0] rd;
   logic [31:0] rd_data;
   logic        rd_write;
   logic [31:0] wb_count;
   logic [2:0]  fifo_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   rf_writeback #(.FIFO_DEPTH(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .chk_addr(chk_addr), .chk_hit(chk_hit),
      .rd(rd), .rd_data(rd_data), .rd_write(rd_write),
      .wb_count(wb_count), .fifo_cnt(fifo_cnt)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int acc;
      reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0; chk_addr = '0;
      tick(); tick();
      reset = 1'b0;

      // Reset state
      check("rst_rd_write", {31'b0, rd_write}, 32'd0);
      check("rst_rd", rd, 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_wb_count", wb_count, 32'd0);
      check("rst_fifo_cnt", {29'b0, fifo_cnt}, 32'd0);
      check("rst_alu_ready", {31'b0, alu_ready}, 32'd1);

      // 1: single ALU write, two-cycle latency
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 1'b0;
      check("t1_cnt1", {29'b0, fifo_cnt}, 32'd1);
      check("t1_no_write_yet", {31'b0, rd_write}, 32'd0);
      tick();
      check("t1_write", {31'b0, rd_write}, 32'd1);
      check("t1_rd", rd, 32'd5);
      check("t1_data", rd_data, 32'hDEADBEEF);
      check("t1_wb", wb_count, 32'd1);
      tick();
      check("t1_pulse_end", {31'b0, rd_write}, 32'd0);
      check("t1_rd_hold", rd, 32'd5);

      // 2: LSU and ALU same cycle, LSU first
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h11;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h22;
      tick();
      lsu_valid = 1'b0; alu_valid = 1'b0;
      check("t2_lsu_write", {31'b0, rd_write}, 32'd1);
      check("t2_lsu_rd", rd, 32'd3);
      check("t2_lsu_data", rd_data, 32'h11);
      tick();
      check("t2_alu_write", {31'b0, rd_write}, 32'd1);
      check("t2_alu_rd", rd, 32'd7);
      check("t2_alu_data", rd_data, 32'h22);
      check("t2_wb", wb_count, 32'd3);

      // 3: LSU stream starves FIFO, ALU back-pressured at full
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h100 + 32'(k);
         alu_valid = 1'b1; alu_rd = 5'(10 + acc); alu_data = 32'hA0 + 32'(acc);
         check($sformatf("t3_ready_%0d", k), {31'b0, alu_ready}, (k < 4) ? 32'd1 : 32'd0);
         if (k < 4) acc++;
         tick();
         check($sformatf("t3_lsu_rd_%0d", k), rd, 32'd1);
         check($sformatf("t3_lsu_data_%0d", k), rd_data, 32'h100 + 32'(k));
      end
      lsu_valid = 1'b0; alu_valid = 1'b0;
      check("t3_full_cnt", {29'b0, fifo_cnt}, 32'd4);
      check("t3_full_no_pass", {31'b0, alu_ready}, 32'd0);
      for (int j = 0; j < 4; j++) begin
         tick();
         check($sformatf("t3_pop_wr_%0d", j), {31'b0, rd_write}, 32'd1);
         check($sformatf("t3_pop_rd_%0d", j), rd, 32'd10 + 32'(j));
         check($sformatf("t3_pop_data_%0d", j), rd_data, 32'hA0 + 32'(j));
         check($sformatf("t3_ready_back_%0d", j), {31'b0, alu_ready}, 32'd1);
      end
      tick();
      check("t3_idle", {31'b0, rd_write}, 32'd0);
      check("t3_empty", {29'b0, fifo_cnt}, 32'd0);
      check("t3_wb", wb_count, 32'd15);

      // 4: ALU x0 accepted but never written
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
      check("t4_ready", {31'b0, alu_ready}, 32'd1);
      tick();
      alu_valid = 1'b0;
      check("t4_cnt1", {29'b0, fifo_cnt}, 32'd1);
      tick();
      check("t4_no_write", {31'b0, rd_write}, 32'd0);
      check("t4_wb_same", wb_count, 32'd15);
      check("t4_drained", {29'b0, fifo_cnt}, 32'd0);
      check("t4_rd_hold", rd, 32'd13);
      check("t4_data_hold", rd_data, 32'hA3);

      // 5: RAW lookup on queued x9 behind LSU
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h55;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      tick();
      alu_valid = 1'b0;
      chk_addr = 5'd9; #1;
      check("t5_hit9", {31'b0, chk_hit}, 32'd1);
      chk_addr = 5'd0; #1;
      check("t5_hit0", {31'b0, chk_hit}, 32'd0);
      chk_addr = 5'd8; #1;
      check("t5_hit8", {31'b0, chk_hit}, 32'd0);
      chk_addr = 5'd9;
      tick();
      check("t5_hit9_held", {31'b0, chk_hit}, 32'd1);
      lsu_valid = 1'b0;
      tick();
      check("t5_pop_rd", rd, 32'd9);
      check("t5_pop_data", rd_data, 32'h99);
      check("t5_hit_cleared", {31'b0, chk_hit}, 32'd0);
      check("t5_wb", wb_count, 32'd18);

      // 6: reset discards queued entries
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
      for (int k = 0; k < 3; k++) begin
         alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_data = 32'h200 + 32'(k);
         tick();
      end
      alu_valid = 1'b0;
      check("t6_cnt3", {29'b0, fifo_cnt}, 32'd3);
      reset = 1'b1; lsu_valid = 1'b0;
      tick();
      check("t6_cnt0", {29'b0, fifo_cnt}, 32'd0);
      check("t6_no_write", {31'b0, rd_write}, 32'd0);
      check("t6_wb0", wb_count, 32'd0);
      check("t6_ready", {31'b0, alu_ready}, 32'd1);
      check("t6_rd0", rd, 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("t6_never_written_%0d", k), {31'b0, rd_write}, 32'd0);
      end
      check("t6_wb_still0", wb_count, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
